// File: rtl/alu_fc_pkg.sv
// Shared constants for the ALU fault classifier: data width, opcodes and fault-type encodings.
// Used by alu_golden and alu_fault_classifier (optional statistics enabled by ALU_FC_STATS_EN).
package alu_fc_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4
  } opcode_e;

  localparam logic [2:0] OP_MAX = 3'd4;

  typedef enum logic [2:0] {
    FT_NONE = 3'd0,
    FT_FLIP = 3'd1,
    FT_OPC  = 3'd2,
    FT_UNK  = 3'd3,
    FT_INV  = 3'd4
  } fault_e;

endpackage

// File: rtl/alu_golden.sv
// Combinational reference ALU: recomputes the correct result for a, b and opcode.
// Undefined opcodes (5-7) produce zero.
module alu_golden
  import alu_fc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        opcode,
  output logic [DATA_W-1:0] golden
);

  always_comb begin
    golden = '0;
    case (opcode)
      OP_ADD:  golden = a + b;
      OP_SUB:  golden = a - b;
      OP_AND:  golden = a & b;
      OP_OR:   golden = a | b;
      OP_XOR:  golden = a ^ b;
      default: golden = '0;
    endcase
  end

endmodule

// File: rtl/alu_fault_classifier.sv
// Two-stage ALU fault classifier with valid/ready handshakes on both sides.
// Per-class statistics counters are built only when ALU_FC_STATS_EN is defined.
module alu_fault_classifier
  import alu_fc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_a,
  input  logic [31:0]       in_b,
  input  logic [2:0]        in_opcode,
  input  logic [31:0]       in_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_fault_type,
  output logic [4:0]        out_flip_bit,
  output logic [31:0]       out_golden,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_none,
  output logic [CNT_W-1:0]  cnt_flip,
  output logic [CNT_W-1:0]  cnt_opc,
  output logic [CNT_W-1:0]  cnt_unk,
  output logic [CNT_W-1:0]  cnt_inv
);

  logic [DATA_W-1:0] golden_c;

  alu_golden u_golden (
    .a      (in_a),
    .b      (in_b),
    .opcode (in_opcode),
    .golden (golden_c)
  );

  logic              vld_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic [2:0]        op_p1;
  logic [DATA_W-1:0] golden_p1;
  logic [DATA_W-1:0] diff_p1;

  logic              vld_p2;
  logic [2:0]        type_p2;
  logic [4:0]        flip_p2;
  logic [DATA_W-1:0] golden_p2;

  logic s2_free;
  logic s1_load;

  assign s2_free  = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || s2_free;
  assign s1_load  = in_valid && in_ready;

  // ---- Stage 1: capture operands, golden result and error syndrome
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      a_p1      <= in_a;
      b_p1      <= in_b;
      op_p1     <= in_opcode;
      golden_p1 <= golden_c;
      diff_p1   <= in_result ^ golden_c;
    end
  end

  logic [DATA_W-1:0] result_p1;
  logic              one_hot_p1;
  logic [4:0]        flip_idx_p1;
  fault_e            type_c;
  logic [4:0]        flip_c;

  // A single flipped bit leaves exactly one bit set in the syndrome.
  always_comb begin
    result_p1   = diff_p1 ^ golden_p1;
    one_hot_p1  = (diff_p1 != '0) && ((diff_p1 & (diff_p1 - DATA_W'(1))) == '0);
    flip_idx_p1 = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (diff_p1[i]) flip_idx_p1 = 5'(i);
    end

    type_c = FT_UNK;
    flip_c = '0;
    if (op_p1 > OP_MAX) begin
      type_c = FT_INV;
    end else if (diff_p1 == '0) begin
      type_c = FT_NONE;
    end else if (result_p1 == (a_p1 ^ b_p1)) begin
      // XOR never reaches here: its golden equals a^b and hits the match case first.
      type_c = FT_OPC;
    end else if (one_hot_p1) begin
      type_c = FT_FLIP;
      flip_c = flip_idx_p1;
    end
  end

  // ---- Stage 2: registered classification, held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      type_p2   <= FT_NONE;
      flip_p2   <= '0;
      golden_p2 <= '0;
    end else if (s2_free) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        type_p2   <= type_c;
        flip_p2   <= flip_c;
        golden_p2 <= golden_p1;
      end
    end
  end

  assign out_valid      = vld_p2;
  assign out_fault_type = type_p2;
  assign out_flip_bit   = flip_p2;
  assign out_golden     = golden_p2;

`ifdef ALU_FC_STATS_EN
  logic             out_hs;
  logic [CNT_W-1:0] cnt_none_q;
  logic [CNT_W-1:0] cnt_flip_q;
  logic [CNT_W-1:0] cnt_opc_q;
  logic [CNT_W-1:0] cnt_unk_q;
  logic [CNT_W-1:0] cnt_inv_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign out_hs = vld_p2 && out_ready;

  // Clear takes precedence over a coincident handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_none_q <= '0;
      cnt_flip_q <= '0;
      cnt_opc_q  <= '0;
      cnt_unk_q  <= '0;
      cnt_inv_q  <= '0;
    end else if (clr_cnt) begin
      cnt_none_q <= '0;
      cnt_flip_q <= '0;
      cnt_opc_q  <= '0;
      cnt_unk_q  <= '0;
      cnt_inv_q  <= '0;
    end else if (out_hs) begin
      case (type_p2)
        FT_NONE: cnt_none_q <= sat_inc(cnt_none_q);
        FT_FLIP: cnt_flip_q <= sat_inc(cnt_flip_q);
        FT_OPC:  cnt_opc_q  <= sat_inc(cnt_opc_q);
        FT_UNK:  cnt_unk_q  <= sat_inc(cnt_unk_q);
        FT_INV:  cnt_inv_q  <= sat_inc(cnt_inv_q);
        default: ;
      endcase
    end
  end

  assign cnt_none = cnt_none_q;
  assign cnt_flip = cnt_flip_q;
  assign cnt_opc  = cnt_opc_q;
  assign cnt_unk  = cnt_unk_q;
  assign cnt_inv  = cnt_inv_q;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;

  assign cnt_none = '0;
  assign cnt_flip = '0;
  assign cnt_opc  = '0;
  assign cnt_unk  = '0;
  assign cnt_inv  = '0;
`endif

endmodule

// File: doc/alu_fault_classifier.md
ALU_FAULT_CLASSIFIER -- requirements
Module: alu_fault_classifier

Interface
REQ-001 Parameter CNT_W, default 16, width of each per-class statistics counter.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  sample offered.
REQ-005 in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-006 in_a, in_b  input  32 each  operands.
REQ-007 in_opcode  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5-7 invalid.
REQ-008 in_result  input  32  observed (possibly faulty) ALU result.
REQ-009 out_valid  output  1  classification available.
REQ-010 out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-011 out_fault_type  output  3  0 none, 1 bitflip, 2 opcode fault, 3 unknown, 4 invalid opcode.
REQ-012 out_flip_bit  output  5  flipped bit index, valid only when type==1, else 0.
REQ-013 out_golden  output  32  recomputed correct result.
REQ-014 clr_cnt  input  1  synchronous clear of all counters.
REQ-015 cnt_none, cnt_flip, cnt_opc, cnt_unk, cnt_inv  output  CNT_W each  per-class totals.

Function
REQ-016 Golden: ADD a+b mod 2^32, SUB a-b mod 2^32 (two's complement wrap), AND, OR, XOR; opcodes 5-7 give golden 0.
REQ-017 Classification priority: opcode>4 -> 4; result==golden -> 0; result==a^b -> 2; popcount(result^golden)==1 -> 1 with index of set bit; else 3.
REQ-018 XOR opcode with result==a^b SHALL classify 0, never 2.
REQ-019 Case matching both 2 and 1 (e.g. OR with single common bit) SHALL classify 2.
REQ-020 Two-stage pipeline: S1 registers operands, golden and diff = result^golden; S2 registers classification outputs.
REQ-021 Latency exactly 2 cycles from accept to out_valid with out_ready held high; throughput 1 sample/cycle.
REQ-022 Backpressure: S2 holds while out_valid && !out_ready; S1 advances only into an empty or draining S2; in_ready = !S1_full || S1 advancing.
REQ-023 Outputs SHALL remain stable while out_valid && !out_ready; no sample dropped or duplicated.
REQ-024 Counter for a class increments by 1 on each output handshake of that class; saturates at all-ones.
REQ-025 clr_cnt coincident with a handshake: clear wins, that sample not counted.

Reset
REQ-026 rst asserted: S1/S2 valid 0, out_valid 0, out_fault_type 0, out_flip_bit 0, out_golden 0, all counters 0; in_ready 1 on the first edge after release.
REQ-027 Reset mid-operation discards in-flight samples without producing output.

Configuration
REQ-028 Macro ALU_FC_STATS_EN defined: counters and clr_cnt logic present per REQ-024/025.
REQ-029 Macro undefined: counter outputs tied to 0, clr_cnt ignored, no counter flops; classification unchanged.

Structure
REQ-030 Package alu_fc_pkg holds opcode constants, fault-type encodings, and the 32-bit data width constant.
REQ-031 One sub-module alu_golden: combinational golden-result function of a, b, opcode.
REQ-032 Popcount-one detection and bit-index encode stay inline in alu_fault_classifier.

Verification
REQ-033 a=5,b=3,op=0,result=8 -> type 0, golden 8, 2 cycles after accept.
REQ-034 a=5,b=3,op=0,result=9 -> type 1, flip_bit 0; result=0x80000008 -> type 1, flip_bit 31.
REQ-035 a=5,b=3,op=0,result=6 -> type 2; same with op=4 -> type 0; op=3,result=6 -> type 2 (priority over bitflip).
REQ-036 a=0xFFFFFFFF,b=1,op=0,result=0xFFFFFFFF -> type 3; op=6 any result -> type 4, golden 0.
REQ-037 Stream 4 samples, out_ready low 3 cycles: in_ready drops after 2 accepts, all 4 emerge in order, outputs stable while stalled.
REQ-038 With ALU_FC_STATS_EN, CNT_W=2: 5 type-0 samples -> cnt_none=3; clr_cnt with handshake -> 0; rst mid-stream -> out_valid 0, counters 0.
